fifo_flex: RTL and testbench
============================

Name: fifo_flex

Overview:
- Parametrised synchronous FIFO. Successor to the 8-bit/16-entry chargen buffer.
- Usable capacity is exactly DEPTH entries; pointers carry an extra wrap bit.
- Adds a selectable first-word-fall-through read mode, a programmable almost-full/almost-empty level, an occupancy count and sticky overflow/underflow error flags.
- Sits between the character generator and the serial/output stages. Used wherever the design needs rate decoupling on a single clock.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of storage entries; power of two, >=2.
- FWFT, 0, read mode: 0 = registered read (1-cycle latency); 1 = first-word-fall-through.
- AFULL_TH, DEPTH-2, n_afull asserts when level >= AFULL_TH (1..DEPTH).
- AEMPTY_TH, 1, n_aempty asserts when level <= AEMPTY_TH (0..DEPTH-1).
- AW, $clog2(DEPTH)+1, pointer/level width; derived, not to be overridden.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- port_in  in  WIDTH  write data.
- n_wr  in  1  write strobe, active-low.
- port_out  out  WIDTH  read data.
- n_rd  in  1  read strobe, active-low.
- n_empty  out  1  active-low empty flag (`nT when level==0).
- n_full  out  1  active-low full flag (`nT when level==DEPTH).
- n_afull  out  1  active-low almost-full flag.
- n_aempty  out  1  active-low almost-empty flag.
- level  out  AW  current occupancy, 0..DEPTH.
- err_clr  in  1  active-high; clears the sticky error flags.
- ovf  out  1  sticky overflow: a write was dropped.
- udf  out  1  sticky underflow: a read was ignored.

Behaviour:
- Reset (rst=1 at a clk edge):
  - rp, wp, level, ovf, udf and port_out all go to 0.
  - n_empty=`nT, n_full=`nF, n_aempty=`nT, n_afull=`nF.
  - Storage contents are don't-care.
  - rst takes priority over all strobes in the same cycle.
  - Reset mid-transfer discards all contents.
- Pointers:
  - rp and wp are AW bits wide and increment modulo 2*DEPTH.
  - Index into storage = low AW-1 bits.
  - Empty when rp==wp.
  - Full when the MSBs differ and the low bits are equal.
  - level = wp - rp, modulo 2^AW.
- All flags are combinational from the registered pointers. They are valid in the cycle following the edge that updated the pointers.
- Write accept = ~n_wr & (not full | read accepted this cycle).
  - Write-on-full is accepted only with a simultaneous accepted read; the level stays DEPTH.
- Read accept = ~n_rd & not empty.
  - A read on empty is never accepted, even with a simultaneous write.
  - The write still lands; level goes 0->1.
- Write not accepted while n_wr is low: data dropped, ovf<=1.
- Read not accepted while n_rd is low: no pointer change, port_out holds, udf<=1.
- ovf and udf hold until err_clr=1 or rst. If err_clr and a new error occur in the same cycle, the new error wins (flag stays 1).
- FWFT=0:
  - On an accepted read, port_out <= mem[rp] at the edge, so data is valid the next cycle.
  - port_out holds between reads.
- FWFT=1:
  - port_out continuously shows mem[rp] while not empty; it is 0 when empty.
  - A word written into an empty FIFO is visible one cycle after the write edge.
  - An accepted read advances to the next word at the edge.
- No combinational path from n_wr/n_rd to any flag.

Decomposition:
- Shared include (common.v): keep `nT/`nF; add a clog2 helper function for AW.
- Sub-module fifo_flex_ram: simple dual-port storage, DEPTH x WIDTH. Synchronous write; read is asynchronous for FWFT=1 and registered for FWFT=0, selected by parameter.
- Pointer, flag and error logic stays in fifo_flex.

Test Plan:
- Fill/drain (WIDTH=8, DEPTH=16, FWFT=0): write 0x00..0x0F with n_rd high.
  - After the 16th write: n_full=`nT, level=16.
  - A 17th write sets ovf=1; level stays 16.
  - Then read 16 words: port_out = 0x00..0x0F, each one cycle after its read strobe.
  - Ends with n_empty=`nT.
- Simultaneous r/w at full: with 16 entries held, assert n_wr and n_rd together for one cycle.
  - level stays 16, ovf stays 0.
  - Read yields the oldest word; the new word appears last on drain.
- Read on empty with write: empty FIFO, n_rd and n_wr low together, data 0x5A.
  - udf=1, level=1.
  - The next read returns 0x5A.
- FWFT=1: write 0xA5 into an empty FIFO.
  - port_out=0xA5 with n_empty=`nF one cycle later, no read needed.
  - Read once: n_empty=`nT, port_out=0.
- Thresholds and wrap (AFULL_TH=14, AEMPTY_TH=1): stream 40 words with interleaved reads so the pointers wrap twice.
  - n_afull is `nT exactly when level>=14; n_aempty is `nT exactly when level<=1.
  - Data order is preserved.
- Reset/clear: assert rst mid-stream at level=7.
  - Next cycle: level=0, n_empty=`nT, ovf=udf=0.
  - A separately forced error cleared with err_clr returns to 0 the next cycle.

Source files
------------

// File: rtl/fifo_flex_pkg.sv
// Shared definitions for the fifo_flex block: active-low flag levels and the
// ceil-log2 helper used to size pointers and the level output.
package fifo_flex_pkg;

  localparam logic N_T = 1'b0;
  localparam logic N_F = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/fifo_flex_ram.sv
// Simple dual-port DEPTH x WIDTH storage. Writes are synchronous; the read
// port is combinational for FWFT mode and registered otherwise.
module fifo_flex_ram
  import fifo_flex_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int FWFT  = 0,
  localparam int IW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [IW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; its contents are don't-care until written,
  // and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      logic unused_rst;
      assign unused_rst = rst;
      // re acts as an output-valid gate here so an empty FIFO reads as zero.
      assign rdata = re ? mem[raddr] : '0;
    end else begin : g_reg
      // Same-cycle write to raddr returns the old word, which is what the
      // read-and-write-at-full case expects.
      always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
      end
    end
  endgenerate

endmodule

// File: rtl/fifo_flex.sv
// Parametrised single-clock FIFO with optional first-word-fall-through,
// programmable almost-full/almost-empty levels and sticky error flags.
module fifo_flex
  import fifo_flex_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 1,
  localparam int AW       = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] port_in,
  input  logic             n_wr,
  output logic [WIDTH-1:0] port_out,
  input  logic             n_rd,
  output logic             n_empty,
  output logic             n_full,
  output logic             n_afull,
  output logic             n_aempty,
  output logic [AW-1:0]    level,
  input  logic             err_clr,
  output logic             ovf,
  output logic             udf
);

  logic [AW-1:0] rp, wp;
  logic          empty, full;
  logic          rd_acc, wr_acc;

  // Flags derive only from the registered pointers, never from the strobes.
  assign level = wp - rp;
  assign empty = (wp == rp);
  assign full  = (wp[AW-1] != rp[AW-1]) && (wp[AW-2:0] == rp[AW-2:0]);

  assign n_empty  = empty ? N_T : N_F;
  assign n_full   = full  ? N_T : N_F;
  assign n_afull  = (level >= AW'(AFULL_TH))  ? N_T : N_F;
  assign n_aempty = (level <= AW'(AEMPTY_TH)) ? N_T : N_F;

  // A write into a full FIFO is allowed only when a read frees the slot.
  assign rd_acc = ~n_rd & ~empty;
  assign wr_acc = ~n_wr & (~full | rd_acc);

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      rp  <= '0;
      wp  <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (rd_acc) rp <= rp + AW'(1);
      if (wr_acc) wp <= wp + AW'(1);
      // A fresh error outranks a simultaneous clear.
      ovf <= (~n_wr & ~wr_acc) | (ovf & ~err_clr);
      udf <= (~n_rd & ~rd_acc) | (udf & ~err_clr);
    end
  end

  fifo_flex_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .FWFT  (FWFT)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wp[AW-2:0]),
    .wdata (port_in),
    .re    ((FWFT != 0) ? ~empty : rd_acc),
    .raddr (rp[AW-2:0]),
    .rdata (port_out)
  );

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: a registered-read and an FWFT instance share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_fifo_flex;

  localparam int W = 8;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] port_in = '0;
  logic         n_wr = 1'b1;
  logic         n_rd = 1'b1;
  logic         err_clr = 1'b0;

  logic [W-1:0] out0, out1;
  logic         n_empty0, n_full0, n_afull0, n_aempty0, ovf0, udf0;
  logic         n_empty1, n_full1, n_afull1, n_aempty1, ovf1, udf1;
  logic [4:0]   level0, level1;

  always #5 clk = ~clk;

  fifo_flex #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AFULL_TH(14), .AEMPTY_TH(1)) u_dut (
    .clk(clk), .rst(rst), .port_in(port_in), .n_wr(n_wr), .port_out(out0),
    .n_rd(n_rd), .n_empty(n_empty0), .n_full(n_full0), .n_afull(n_afull0),
    .n_aempty(n_aempty0), .level(level0), .err_clr(err_clr), .ovf(ovf0), .udf(udf0)
  );

  fifo_flex #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AFULL_TH(14), .AEMPTY_TH(1)) u_dut_fwft (
    .clk(clk), .rst(rst), .port_in(port_in), .n_wr(n_wr), .port_out(out1),
    .n_rd(n_rd), .n_empty(n_empty1), .n_full(n_full1), .n_afull(n_afull1),
    .n_aempty(n_aempty1), .level(level1), .err_clr(err_clr), .ovf(ovf1), .udf(udf1)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: contents as a queue, plus sticky flags and the last word
  // handed out by the registered-read instance.
  logic [W-1:0] q[$];
  logic         m_ovf = 1'b0;
  logic         m_udf = 1'b0;
  logic [W-1:0] m_out0 = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    logic [W-1:0] head;
    n = q.size();
    head = (n > 0) ? q[0] : '0;
    check("level0",   32'(level0),   32'(n));
    check("level1",   32'(level1),   32'(n));
    check("n_empty0", 32'(n_empty0), 32'(n != 0));
    check("n_empty1", 32'(n_empty1), 32'(n != 0));
    check("n_full0",  32'(n_full0),  32'(n != D));
    check("n_full1",  32'(n_full1),  32'(n != D));
    check("n_afull0", 32'(n_afull0), 32'(!(n >= 14)));
    check("n_afull1", 32'(n_afull1), 32'(!(n >= 14)));
    check("n_aempty0", 32'(n_aempty0), 32'(!(n <= 1)));
    check("n_aempty1", 32'(n_aempty1), 32'(!(n <= 1)));
    check("ovf0", 32'(ovf0), 32'(m_ovf));
    check("ovf1", 32'(ovf1), 32'(m_ovf));
    check("udf0", 32'(udf0), 32'(m_udf));
    check("udf1", 32'(udf1), 32'(m_udf));
    check("out_reg",  32'(out0), 32'(m_out0));
    check("out_fwft", 32'(out1), 32'(head));
  endtask

  // One clock of stimulus; wr/rd/clr/r are active-high requests here.
  task automatic step(input logic wr, input logic rd, input logic [W-1:0] d,
                      input logic clr = 1'b0, input logic r = 1'b0);
    bit rd_ok, wr_ok;
    rst     = r;
    n_wr    = ~wr;
    n_rd    = ~rd;
    port_in = d;
    err_clr = clr;
    if (r) begin
      q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_out0 = '0;
    end else begin
      rd_ok = rd && (q.size() > 0);
      wr_ok = wr && ((q.size() < D) || rd_ok);
      if (rd_ok) m_out0 = q.pop_front();
      if (wr_ok) q.push_back(d);
      m_ovf = (wr && !wr_ok) || (m_ovf && !clr);
      m_udf = (rd && !rd_ok) || (m_udf && !clr);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    // Reset, with strobes active to show reset priority.
    step(1'b1, 1'b1, 8'h33, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00);

    // Fill 0x00..0x0F, then one write too many.
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'(i));
    check("fill_level", 32'(level0), 32'd16);
    check("fill_nfull", 32'(n_full0), 32'd0);
    step(1'b1, 1'b0, 8'hFF);
    check("ovf_set", 32'(ovf0), 32'd1);
    check("ovf_level", 32'(level0), 32'd16);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, 8'h00);
    check("drain_last", 32'(out0), 32'h0F);
    check("drain_empty", 32'(n_empty0), 32'd0);

    // Simultaneous read and write while full.
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'(8'h20 + i));
    step(1'b1, 1'b1, 8'hEE);
    check("rw_full_level", 32'(level0), 32'd16);
    check("rw_full_ovf", 32'(ovf0), 32'd0);
    check("rw_full_oldest", 32'(out0), 32'h20);
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, 8'h00);
    check("rw_full_newlast", 32'(out0), 32'hEE);

    // Read on empty together with a write.
    step(1'b1, 1'b1, 8'h5A);
    check("rd_empty_udf", 32'(udf0), 32'd1);
    check("rd_empty_level", 32'(level0), 32'd1);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    check("rd_empty_data", 32'(out0), 32'h5A);

    // Fall-through visibility on the FWFT instance.
    step(1'b1, 1'b0, 8'hA5);
    check("fwft_show", 32'(out1), 32'hA5);
    check("fwft_nempty", 32'(n_empty1), 32'd1);
    step(1'b0, 1'b1, 8'h00);
    check("fwft_gone", 32'(out1), 32'h00);
    check("fwft_empty", 32'(n_empty1), 32'd0);

    // Random streaming: write-heavy then read-heavy, wrapping pointers often.
    for (int i = 0; i < 400; i++) begin
      logic wr, rd, clr;
      wr  = $urandom_range(99) < ((i < 200) ? 70 : 35);
      rd  = $urandom_range(99) < ((i < 200) ? 35 : 70);
      clr = $urandom_range(9) == 0;
      step(wr, rd, W'($urandom), clr);
    end

    // Reset in the middle of a stream at level 7.
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, W'($urandom));
    check("pre_rst_level", 32'(level0), 32'd7);
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
    check("post_rst_level", 32'(level0), 32'd0);
    check("post_rst_empty", 32'(n_empty0), 32'd0);

    // Forced underflow; clear colliding with a new error keeps it, then clears.
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    check("clr_vs_err", 32'(udf0), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("clr_done", 32'(udf0), 32'd0);
    step(1'b0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
